// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit CPU: owns pc and inst, runs the
// shared memory port with a req/rdy handshake and strobes the A/B file and ALU.
module cpu_sequencer #(
    parameter logic [7:0]  RESET_PC     = 8'h00,
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_in_i,
    input  logic       mem_rdy_i,
    input  logic [7:0] a_in_i,
    input  logic       a_zero_i,
    output logic       mem_req_o,
    output logic [7:0] addr_o,
    output logic       we_o,
    output logic [7:0] data_out_o,
    output logic [7:0] inst_o,
    output logic       alu_en_o,
    output logic       ld_a_o,
    output logic       ld_b_o,
    output logic [7:0] ld_data_o,
    output logic       halted_o,
    output logic       bus_err_o
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_OPERAND = 3'd2;
    localparam logic [2:0] S_MEM_RD  = 3'd3;
    localparam logic [2:0] S_MEM_WR  = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    localparam logic [7:0] OP_LDA_IMM = 8'h01;
    localparam logic [7:0] OP_LDB_IMM = 8'h02;
    localparam logic [7:0] OP_LDA_MEM = 8'h03;
    localparam logic [7:0] OP_STA     = 8'h04;
    localparam logic [7:0] OP_JMP     = 8'h05;
    localparam logic [7:0] OP_JZ      = 8'h06;
    localparam logic [7:0] OP_HLT     = 8'hFF;

    localparam bit          TIMEOUT_ON  = (WAIT_TIMEOUT != 0);
    localparam logic [15:0] TIMEOUT_LIM = 16'(WAIT_TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  inst_q, inst_d;
    logic [7:0]  opnd_q, opnd_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        alu_en_q, alu_en_d;
    logic        ld_a_q, ld_a_d;
    logic        ld_b_q, ld_b_d;
    logic [7:0]  ld_data_q, ld_data_d;
    logic        bus_err_q, bus_err_d;

    logic        mem_state;
    logic        we_state;
    logic        access_stall;
    logic        timeout_hit;
    logic        is_alu_op;
    logic        has_operand;

    always_comb begin
        mem_state  = 1'b0;
        we_state   = 1'b0;
        addr_o     = 8'h00;
        data_out_o = 8'h00;
        case (state_q)
            S_FETCH, S_OPERAND: begin
                mem_state = 1'b1;
                addr_o    = pc_q;
            end
            S_MEM_RD: begin
                mem_state = 1'b1;
                addr_o    = opnd_q;
            end
            S_MEM_WR: begin
                mem_state  = 1'b1;
                we_state   = 1'b1;
                addr_o     = opnd_q;
                data_out_o = a_in_i;
            end
            default: begin
                mem_state = 1'b0;
            end
        endcase
    end

    // While reset is held the bus stays quiet, so an aborted write never lingers.
    assign mem_req_o = mem_state & ~rst_i;
    assign we_o      = we_state & ~rst_i;

    assign access_stall = mem_state & ~mem_rdy_i;
    assign timeout_hit  = TIMEOUT_ON && access_stall && ((wait_cnt_q + 16'd1) == TIMEOUT_LIM);
    assign is_alu_op    = (inst_q[7:3] == 5'b00010);
    assign has_operand  = (inst_q >= OP_LDA_IMM) && (inst_q <= OP_JZ);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        opnd_d     = opnd_q;
        ld_data_d  = ld_data_q;
        bus_err_d  = bus_err_q;
        alu_en_d   = 1'b0;
        ld_a_d     = 1'b0;
        ld_b_d     = 1'b0;
        wait_cnt_d = access_stall ? (wait_cnt_q + 16'd1) : 16'd0;

        if (timeout_hit) begin
            bus_err_d  = 1'b1;
            wait_cnt_d = 16'd0;
            state_d    = S_HALT;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_rdy_i) begin
                        inst_d  = data_in_i;
                        pc_d    = pc_q + 8'd1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_d = S_FETCH;
                    if (is_alu_op) begin
                        alu_en_d = 1'b1;
                    end else if (has_operand) begin
                        state_d = S_OPERAND;
                    end else if (inst_q == OP_HLT) begin
                        state_d = S_HALT;
                    end
                end
                S_OPERAND: begin
                    if (mem_rdy_i) begin
                        opnd_d  = data_in_i;
                        pc_d    = pc_q + 8'd1;
                        state_d = S_FETCH;
                        case (inst_q)
                            OP_LDA_IMM: begin
                                ld_a_d    = 1'b1;
                                ld_data_d = data_in_i;
                            end
                            OP_LDB_IMM: begin
                                ld_b_d    = 1'b1;
                                ld_data_d = data_in_i;
                            end
                            OP_LDA_MEM: state_d = S_MEM_RD;
                            OP_STA:     state_d = S_MEM_WR;
                            OP_JMP:     pc_d = data_in_i;
                            OP_JZ: begin
                                if (a_zero_i) begin
                                    pc_d = data_in_i;
                                end
                            end
                            default: begin
                                state_d = S_FETCH;
                            end
                        endcase
                    end
                end
                S_MEM_RD: begin
                    if (mem_rdy_i) begin
                        ld_a_d    = 1'b1;
                        ld_data_d = data_in_i;
                        state_d   = S_FETCH;
                    end
                end
                S_MEM_WR: begin
                    if (mem_rdy_i) begin
                        state_d = S_FETCH;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= 8'h00;
            opnd_q     <= 8'h00;
            wait_cnt_q <= 16'd0;
            alu_en_q   <= 1'b0;
            ld_a_q     <= 1'b0;
            ld_b_q     <= 1'b0;
            ld_data_q  <= 8'h00;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            opnd_q     <= opnd_d;
            wait_cnt_q <= wait_cnt_d;
            alu_en_q   <= alu_en_d;
            ld_a_q     <= ld_a_d;
            ld_b_q     <= ld_b_d;
            ld_data_q  <= ld_data_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign inst_o    = inst_q;
    assign alu_en_o  = alu_en_q;
    assign ld_a_o    = ld_a_q;
    assign ld_b_o    = ld_b_q;
    assign ld_data_o = ld_data_q;
    assign halted_o  = (state_q == S_HALT);
    assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: an instruction-level model of the ISA acts as
// memory and predicts bus accesses, strobes and halt/bus-error on every cycle.
module tb_cpu_sequencer;

    localparam logic [7:0] TB_RESET_PC = 8'hFE;
    localparam int         TB_TIMEOUT  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dataIn;
    logic       memRdy;
    logic [7:0] aIn;
    logic       aZero;
    logic       memReqO;
    logic [7:0] addrO;
    logic       weO;
    logic [7:0] dataOutO;
    logic [7:0] instO;
    logic       aluEnO;
    logic       ldAO;
    logic       ldBO;
    logic [7:0] ldDataO;
    logic       haltedO;
    logic       busErrO;

    always #5 clk = ~clk;

    cpu_sequencer #(
        .RESET_PC    (TB_RESET_PC),
        .WAIT_TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .data_in_i (dataIn),
        .mem_rdy_i (memRdy),
        .a_in_i    (aIn),
        .a_zero_i  (aZero),
        .mem_req_o (memReqO),
        .addr_o    (addrO),
        .we_o      (weO),
        .data_out_o(dataOutO),
        .inst_o    (instO),
        .alu_en_o  (aluEnO),
        .ld_a_o    (ldAO),
        .ld_b_o    (ldBO),
        .ld_data_o (ldDataO),
        .halted_o  (haltedO),
        .bus_err_o (busErrO)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mem [256];

    // Instruction-level model: which access the program needs next and what it yields.
    typedef enum {K_FETCH, K_OPERAND, K_READ, K_WRITE} kind_t;
    kind_t      mKind;
    logic [7:0] mPc;
    logic [7:0] mInst;
    logic [7:0] mAddr;
    logic [7:0] mLdData;
    bit         mHalted;
    bit         mBusErr;
    bit         mHaltAfterGap;
    bit         mLdValid;
    int         mGap;
    int         mWait;
    int         waitLeft;
    int         aluCd;
    int         ldACd;
    int         ldBCd;

    int         delayMode;
    int         fixedDelay;
    bit         holdA;

    int         cycleIdx;
    logic [7:0] accLog [$];
    int         writeCount;
    int         aluPulses;
    int         firstAlu;
    int         firstHalt;
    int         weHits;
    int         weAny;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic randomizeA();
        aIn   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        aZero = (aIn == 8'h00);
    endtask

    task automatic newAccess();
        mWait = 0;
        case (delayMode)
            0: waitLeft = 0;
            1: waitLeft = ($urandom_range(0, 99) < 3) ? 100 : $urandom_range(0, 3);
            2: waitLeft = fixedDelay;
            default: waitLeft = 1000;
        endcase
    endtask

    task automatic modelReset();
        mPc           = TB_RESET_PC;
        mInst         = 8'h00;
        mKind         = K_FETCH;
        mGap          = 0;
        mHalted       = 1'b0;
        mBusErr       = 1'b0;
        mHaltAfterGap = 1'b0;
        mLdValid      = 1'b0;
        aluCd         = 0;
        ldACd         = 0;
        ldBCd         = 0;
        cycleIdx      = 0;
        accLog.delete();
        writeCount    = 0;
        aluPulses     = 0;
        firstAlu      = -1;
        firstHalt     = -1;
        weHits        = 0;
        weAny         = 0;
        newAccess();
    endtask

    task automatic completeAccess(input logic [7:0] d);
        case (mKind)
            K_FETCH: begin
                mInst         = d;
                mPc           = mPc + 8'd1;
                mGap          = 1;
                mHaltAfterGap = 1'b0;
                mKind         = K_FETCH;
                if (d inside {[8'h10:8'h17]}) aluCd = 2;
                else if (d inside {[8'h01:8'h06]}) mKind = K_OPERAND;
                else if (d == 8'hFF) mHaltAfterGap = 1'b1;
            end
            K_OPERAND: begin
                mPc   = mPc + 8'd1;
                mKind = K_FETCH;
                case (mInst)
                    8'h01: begin ldACd = 1; mLdData = d; mLdValid = 1'b1; end
                    8'h02: begin ldBCd = 1; mLdData = d; mLdValid = 1'b1; end
                    8'h03: begin mAddr = d; mKind = K_READ; end
                    8'h04: begin mAddr = d; mKind = K_WRITE; end
                    8'h05: mPc = d;
                    8'h06: if (aZero) mPc = d;
                    default: mKind = K_FETCH;
                endcase
                newAccess();
            end
            K_READ: begin
                ldACd    = 1;
                mLdData  = d;
                mLdValid = 1'b1;
                mKind    = K_FETCH;
                newAccess();
            end
            default: begin
                mem[mAddr] = aIn;
                writeCount++;
                mKind = K_FETCH;
                newAccess();
            end
        endcase
    endtask

    // Called at each negedge: compare outputs to the model, then drive the next edge.
    task automatic applyStimulus();
        bit         expReq;
        logic [7:0] expAddr;
        expReq  = !mHalted && (mGap == 0);
        expAddr = (mKind == K_FETCH || mKind == K_OPERAND) ? mPc : mAddr;
        checkOutput("mem_req", memReqO, expReq);
        checkOutput("halted", haltedO, mHalted);
        checkOutput("bus_err", busErrO, mBusErr);
        checkOutput("inst", instO, mInst);
        checkOutput("alu_en", aluEnO, aluCd == 1);
        checkOutput("ld_a", ldAO, ldACd == 1);
        checkOutput("ld_b", ldBO, ldBCd == 1);
        if (mLdValid) checkOutput("ld_data", ldDataO, mLdData);
        if (expReq) begin
            checkOutput("addr", addrO, expAddr);
            checkOutput("we", weO, mKind == K_WRITE);
            if (mKind == K_WRITE) checkOutput("data_out", dataOutO, aIn);
        end

        if (aluEnO) begin
            aluPulses++;
            if (firstAlu < 0) firstAlu = cycleIdx;
        end
        if (haltedO && firstHalt < 0) firstHalt = cycleIdx;
        if (memReqO && weO) weAny++;
        if (memReqO && weO && addrO == 8'h80 && dataOutO == 8'hC3) weHits++;

        if (aluCd > 0) aluCd--;
        if (ldACd > 0) ldACd--;
        if (ldBCd > 0) ldBCd--;

        memRdy = 1'($urandom_range(0, 1));
        dataIn = 8'($urandom);
        if (mHalted) begin
            if (!holdA) randomizeA();
        end else if (mGap > 0) begin
            if (!holdA) randomizeA();
            mGap--;
            if (mGap == 0) begin
                if (mHaltAfterGap) mHalted = 1'b1;
                else newAccess();
            end
        end else if (waitLeft > 0) begin
            memRdy = 1'b0;
            waitLeft--;
            mWait++;
            if (TB_TIMEOUT != 0 && mWait == TB_TIMEOUT) begin
                mHalted = 1'b1;
                mBusErr = 1'b1;
            end
        end else begin
            memRdy = 1'b1;
            if (mKind != K_WRITE) dataIn = mem[expAddr];
            accLog.push_back(expAddr);
            completeAccess(dataIn);
        end
        cycleIdx++;
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            applyStimulus();
        end
    endtask

    task automatic applyReset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(negedge clk);
            checkOutput("rst mem_req", memReqO, 1'b0);
            checkOutput("rst we", weO, 1'b0);
            checkOutput("rst halted", haltedO, 1'b0);
            checkOutput("rst bus_err", busErrO, 1'b0);
            checkOutput("rst strobes", {aluEnO, ldAO, ldBO}, 3'b000);
            checkOutput("rst inst", instO, 8'h00);
            memRdy = 1'($urandom_range(0, 1));
            dataIn = 8'($urandom);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        memRdy     = 1'b0;
        dataIn     = 8'h00;
        aIn        = 8'h00;
        aZero      = 1'b1;
        delayMode  = 0;
        fixedDelay = 0;
        holdA      = 1'b0;
        clearMem();
        modelReset();

        // LDA #5A then HLT, starting at RESET_PC and wrapping through 00
        clearMem();
        mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h5A; mem[8'h00] = 8'hFF;
        delayMode = 0;
        applyReset(2);
        runCycles(8);
        checkOutput("t1 halt cycle", 16'(firstHalt), 16'd5);
        checkOutput("t1 ld_data", ldDataO, 8'h5A);
        checkOutput("t1 access count", 16'(accLog.size()), 16'd3);
        if (accLog.size() == 3) checkOutput("t1 third addr", accLog[2], 8'h00);

        // single ALU op: one alu_en pulse two cycles after fetch starts
        clearMem();
        mem[8'hFE] = 8'h10;
        applyReset(1);
        runCycles(6);
        checkOutput("t2 alu pulses", 16'(aluPulses), 16'd1);
        checkOutput("t2 alu cycle", 16'(firstAlu), 16'd2);

        // STA [80] with three wait cycles per access
        clearMem();
        mem[8'hFE] = 8'h04; mem[8'hFF] = 8'h80;
        holdA = 1'b1; aIn = 8'hC3; aZero = 1'b0;
        delayMode = 2; fixedDelay = 3;
        applyReset(1);
        runCycles(16);
        checkOutput("t3 write cycles", 16'(weHits), 16'd4);
        checkOutput("t3 we cycles", 16'(weAny), 16'd4);
        checkOutput("t3 writes", 16'(writeCount), 16'd1);
        checkOutput("t3 mem[80]", mem[8'h80], 8'hC3);

        // reset while the write is still waiting for rdy
        clearMem();
        mem[8'hFE] = 8'h04; mem[8'hFF] = 8'h80;
        applyReset(1);
        runCycles(10);
        checkOutput("t3b mid write", weO, 1'b1);
        applyReset(1);
        checkOutput("t3b no write", 16'(writeCount), 16'd0);
        delayMode = 0;

        // JZ taken and not taken
        clearMem();
        mem[8'hFE] = 8'h06; mem[8'hFF] = 8'h40;
        aIn = 8'h00; aZero = 1'b1;
        applyReset(1);
        runCycles(5);
        if (accLog.size() >= 3) checkOutput("t4 jz taken", accLog[2], 8'h40);
        else checkOutput("t4 jz taken count", 16'(accLog.size()), 16'd3);
        aIn = 8'h55; aZero = 1'b0;
        applyReset(1);
        runCycles(5);
        if (accLog.size() >= 3) checkOutput("t4 jz not taken", accLog[2], 8'h00);
        else checkOutput("t4 jz nt count", 16'(accLog.size()), 16'd3);
        holdA = 1'b0;

        // pc wrap: NOP at FE, JMP at FF with operand at 00
        clearMem();
        mem[8'hFE] = 8'h00; mem[8'hFF] = 8'h05; mem[8'h00] = 8'h10;
        applyReset(1);
        runCycles(7);
        checkOutput("t5 access count", 16'(accLog.size()), 16'd4);
        if (accLog.size() >= 4) begin
            checkOutput("t5 operand addr", accLog[2], 8'h00);
            checkOutput("t5 jump target", accLog[3], 8'h10);
        end

        // memory never ready: timeout after four wait cycles, cleared by reset
        clearMem();
        delayMode = 3;
        applyReset(1);
        runCycles(8);
        checkOutput("t6 halt cycle", 16'(firstHalt), 16'd4);
        checkOutput("t6 bus_err", busErrO, 1'b1);
        delayMode = 0;
        applyReset(2);
        runCycles(1);
        checkOutput("t6 refetch addr", 16'(accLog.size() > 0 ? accLog[0] : 8'h00), 16'(TB_RESET_PC));

        // random programs, random handshakes, random reset points
        delayMode = 1;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 256; i++) begin
                int pick;
                pick = $urandom_range(0, 99);
                if (pick < 2) mem[i] = 8'hFF;
                else if (pick < 40) mem[i] = 8'($urandom_range(0, 6));
                else if (pick < 60) mem[i] = 8'h10 + 8'($urandom_range(0, 7));
                else mem[i] = 8'($urandom);
            end
            applyReset($urandom_range(1, 3));
            runCycles($urandom_range(40, 200));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
